// File: rtl/ex_wb_stage_pkg.sv
// Shared definitions for the EX->WB stage: opcode encodings, opcode class helpers,
// flag bit indices and datapath width defaults.
package ex_wb_stage_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned RW_DEF = 3;

  localparam logic [15:0] Zero16 = 16'h0000;

  // Opcode encodings
  localparam logic [4:0] OpAdd = 5'h00;
  localparam logic [4:0] OpAdc = 5'h01;
  localparam logic [4:0] OpSub = 5'h02;
  localparam logic [4:0] OpSbc = 5'h03;
  localparam logic [4:0] OpCmp = 5'h04;
  localparam logic [4:0] OpAnd = 5'h08;
  localparam logic [4:0] OpOr  = 5'h09;
  localparam logic [4:0] OpXor = 5'h0a;
  localparam logic [4:0] OpNot = 5'h0b;
  localparam logic [4:0] OpShl = 5'h0c;
  localparam logic [4:0] OpShr = 5'h0d;
  localparam logic [4:0] OpMov = 5'h10;

  // Bit positions inside the architectural flag vector
  localparam int unsigned FlagZf = 0;
  localparam int unsigned FlagNf = 1;
  localparam int unsigned FlagCf = 2;

  function automatic logic is_add_op(logic [4:0] op);
    return (op == OpAdd) || (op == OpAdc);
  endfunction

  function automatic logic is_sub_op(logic [4:0] op);
    return (op == OpSub) || (op == OpSbc) || (op == OpCmp);
  endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// Writeback channel between the EX->WB stage (master) and the register file (slave).
//   valid/ready : handshake for the head queue entry
//   rd/data/we  : destination register, write data, write enable of the head entry
interface ex_wb_stage_if
  import ex_wb_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
);
  logic          valid;
  logic          ready;
  logic [RW-1:0] rd;
  logic [DW-1:0] data;
  logic          we;

  modport master (output valid, rd, data, we, input ready);
  modport slave  (input valid, rd, data, we, output ready);
endinterface

// File: rtl/ex_wb_stage_skid_buf.sv
// Two-entry skid queue toward register-file writeback.
//   clock, rst_n           : clock, async active-low reset
//   flush                  : empties the queue next cycle, drops a same-cycle push
//   in_valid/in_ready      : push handshake (in_ready registered, low only while full)
//   in_rd/in_data/in_we    : pushed entry
//   wb                     : head entry toward the register file
//   fwd_valid/rd/data      : newest queued entry, valid only when it writes a register
module ex_wb_stage_skid_buf
  import ex_wb_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rd,
  input  logic [DW-1:0] in_data,
  input  logic          in_we,
  ex_wb_stage_if.master wb,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data
);

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          we;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q;
  entry_t head_q, tail_q, in_e, newest;
  logic   ready_q, acc, pop;

  always_comb begin
    in_e      = '0;
    in_e.rd   = in_rd;
    in_e.data = in_data;
    in_e.we   = in_we;
  end

  assign acc = in_valid & ready_q & ~flush;
  assign pop = (state_q != StEmpty) & wb.ready & ~flush;

  // Vacated slots are zeroed so idle outputs read as zero.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            head_q  <= in_e;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (acc && pop) begin
            head_q <= in_e;
          end else if (acc) begin
            tail_q  <= in_e;
            state_q <= StFull;
            ready_q <= 1'b0;
          end else if (pop) begin
            head_q  <= '0;
            state_q <= StEmpty;
          end
        end
        StFull: begin
          // ready_q is low here, so only a pop can happen
          if (pop) begin
            head_q  <= tail_q;
            tail_q  <= '0;
            state_q <= StOne;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StEmpty;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = ready_q;

  assign wb.valid = (state_q != StEmpty);
  assign wb.rd    = head_q.rd;
  assign wb.data  = head_q.data;
  assign wb.we    = head_q.we;

  assign newest    = (state_q == StFull) ? tail_q : head_q;
  assign fwd_valid = (state_q != StEmpty) & newest.we;
  assign fwd_rd    = newest.rd;
  assign fwd_data  = newest.data;

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB stage: captures ALU results into a 2-entry writeback skid queue, keeps the
// architectural flags (committed at accept, in program order) and feeds CF back to the ALU.
// Optional macro OVERFLOW_FLAG_EN adds the signed-overflow flag vf; otherwise vf is tied 0.
//   clock, rst_n, flush     : clock, async active-low reset, pipeline flush
//   ex_valid/ex_ready       : EX handshake (ex_ready registered)
//   ex_op/rd/we/setf        : instruction info; alu_res/alu_cf/alu_a_msb/alu_b_msb: ALU outputs
//   cf_to_alu, zf/nf/cf/vf  : flag outputs
//   wb                      : writeback channel (master)
//   fwd_valid/rd/data       : bypass tap of the newest queued entry
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [4:0]    ex_op,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_we,
  input  logic          ex_setf,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_cf,
  input  logic          alu_a_msb,
  input  logic          alu_b_msb,
  output logic          cf_to_alu,
  output logic          zf,
  output logic          nf,
  output logic          cf,
  output logic          vf,
  ex_wb_stage_if.master wb,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data
);

  logic       accept, upd;
  logic [2:0] flags_q, flags_d;

  assign accept = ex_valid & ex_ready & ~flush;
  assign upd    = accept & ex_setf;

  ex_wb_stage_skid_buf #(
    .DW (DW),
    .RW (RW)
  ) u_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_rd     (ex_rd),
    .in_data   (alu_res),
    .in_we     (ex_we),
    .wb        (wb),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
  );

  always_comb begin
    flags_d = flags_q;
    if (upd) begin
      flags_d[FlagZf] = (alu_res == DW'(Zero16));
      flags_d[FlagNf] = alu_res[DW-1];
      flags_d[FlagCf] = alu_cf;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign zf        = flags_q[FlagZf];
  assign nf        = flags_q[FlagNf];
  assign cf        = flags_q[FlagCf];
  assign cf_to_alu = flags_q[FlagCf];

`ifdef OVERFLOW_FLAG_EN
  logic vf_q, vf_d;

  always_comb begin
    vf_d = vf_q;
    if (upd) begin
      if (is_add_op(ex_op)) begin
        vf_d = (alu_a_msb == alu_b_msb) & (alu_res[DW-1] != alu_a_msb);
      end else if (is_sub_op(ex_op)) begin
        vf_d = (alu_a_msb != alu_b_msb) & (alu_res[DW-1] != alu_a_msb);
      end else begin
        vf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vf_q <= 1'b0;
    end else begin
      vf_q <= vf_d;
    end
  end

  assign vf = vf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ex_op, alu_a_msb, alu_b_msb};
  assign vf         = 1'b0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: directed scenarios plus randomized traffic against a
// queue-based reference model of the writeback queue and flag behaviour.
module tb_ex_wb_stage;
  import ex_wb_stage_pkg::*;

`ifdef OVERFLOW_FLAG_EN
  localparam bit VfOn = 1'b1;
`else
  localparam bit VfOn = 1'b0;
`endif

  logic        clock, rst_n, flush, ex_valid, ex_ready, ex_we, ex_setf;
  logic [4:0]  ex_op;
  logic [2:0]  ex_rd, fwd_rd;
  logic [15:0] alu_res, fwd_data;
  logic        alu_cf, alu_a_msb, alu_b_msb, cf_to_alu, zf, nf, cf, vf, fwd_valid;

  ex_wb_stage_if #(.DW(16), .RW(3)) wb_if ();

  ex_wb_stage #(.DW(16), .RW(3)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op     (ex_op),
    .ex_rd     (ex_rd),
    .ex_we     (ex_we),
    .ex_setf   (ex_setf),
    .alu_res   (alu_res),
    .alu_cf    (alu_cf),
    .alu_a_msb (alu_a_msb),
    .alu_b_msb (alu_b_msb),
    .cf_to_alu (cf_to_alu),
    .zf        (zf),
    .nf        (nf),
    .cf        (cf),
    .vf        (vf),
    .wb        (wb_if),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    logic        we;
  } ent_t;

  ent_t mq[$];
  bit   m_zf, m_nf, m_cf, m_vf;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_vf(logic [4:0] op, bit a, bit b, bit r);
    // Signed overflow: result sign disagrees with what the operand signs force.
    if (op == OpAdd || op == OpAdc) return (a == b) && (r != a);
    if (op == OpSub || op == OpSbc || op == OpCmp) return (a != b) && (r != a);
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_zf = 0; m_nf = 0; m_cf = 0; m_vf = 0;
  endtask

  task automatic compare_all();
    check("ex_ready", 32'(ex_ready), 32'(mq.size() < 2));
    check("wb_valid", 32'(wb_if.valid), 32'(mq.size() > 0));
    if (mq.size() > 0)
      check("wb_head", {wb_if.rd, wb_if.data, wb_if.we}, {mq[0].rd, mq[0].data, mq[0].we});
    check("fwd_valid", 32'(fwd_valid), 32'(mq.size() > 0 && mq[$].we));
    if (mq.size() > 0 && mq[$].we)
      check("fwd_entry", {fwd_rd, fwd_data}, {mq[$].rd, mq[$].data});
    check("flags", {zf, nf, cf, cf_to_alu, vf}, {m_zf, m_nf, m_cf, m_cf, VfOn ? m_vf : 1'b0});
  endtask

  task automatic drive(input bit v, input logic [4:0] op, input logic [2:0] rd, input bit we,
                       input bit setf, input logic [15:0] res, input bit c, input bit am,
                       input bit bm, input bit wbr, input bit fl);
    ex_valid = v; ex_op = op; ex_rd = rd; ex_we = we; ex_setf = setf; alu_res = res;
    alu_cf = c; alu_a_msb = am; alu_b_msb = bm; wb_if.ready = wbr; flush = fl;
  endtask

  // One clock: model advances with the edge, outputs compared on the following negedge.
  task automatic tick();
    bit   acc, pop;
    ent_t e;
    acc = ex_valid && (mq.size() < 2) && !flush;
    pop = (mq.size() > 0) && wb_if.ready && !flush;
    e.rd = ex_rd; e.data = alu_res; e.we = ex_we;
    @(posedge clock);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    if (acc && ex_setf) begin
      m_zf = (alu_res == 16'h0);
      m_nf = alu_res[15];
      m_cf = alu_cf;
      m_vf = model_vf(ex_op, alu_a_msb, alu_b_msb, alu_res[15]);
    end
    @(negedge clock);
    compare_all();
  endtask

  logic [4:0] ops [12];

  initial begin
    ops = '{OpAdd, OpAdc, OpSub, OpSbc, OpCmp, OpAnd, OpOr, OpXor, OpNot, OpShl, OpShr, OpMov};
    rst_n = 1'b0;
    drive(0, OpAdd, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_wb_valid", 32'(wb_if.valid), 0);
    check("rst_ex_ready", 32'(ex_ready), 1);
    check("rst_wb_bus", {wb_if.rd, wb_if.data, wb_if.we}, 0);
    check("rst_fwd", {fwd_valid, fwd_rd, fwd_data}, 0);
    check("rst_flags", {zf, nf, cf, vf, cf_to_alu}, 0);
    rst_n = 1'b1;

    // ADD producing zero with carry out
    drive(1, OpAdd, 3'd1, 1, 1, 16'h0000, 1, 0, 0, 0, 0); tick();
    check("t1_flags", {zf, nf, cf, cf_to_alu}, 4'b1011);
    check("t1_wb", {wb_if.valid, wb_if.data}, {1'b1, 16'h0000});
    drive(0, OpAdd, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0); tick();

    // Backpressure: third request is held until a slot frees
    drive(1, OpMov, 3'd2, 1, 0, 16'haaaa, 0, 0, 0, 0, 0); tick();
    drive(1, OpMov, 3'd3, 1, 0, 16'hbbbb, 0, 0, 0, 0, 0); tick();
    drive(1, OpMov, 3'd4, 1, 0, 16'hcccc, 0, 0, 0, 0, 0); tick();
    check("t2_ready_low", 32'(ex_ready), 0);
    check("t2_head_a", 32'(wb_if.data), 32'h aaaa);
    drive(1, OpMov, 3'd4, 1, 0, 16'hcccc, 0, 0, 0, 1, 0); tick();
    check("t2_head_b", 32'(wb_if.data), 32'h bbbb);
    drive(1, OpMov, 3'd4, 1, 0, 16'hcccc, 0, 0, 0, 1, 0); tick();
    check("t2_head_c", 32'(wb_if.data), 32'h cccc);
    drive(0, OpMov, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0); tick();

    // Logic op clears carry, setf=0 holds flags
    drive(1, OpAdd, 3'd1, 1, 1, 16'h0001, 1, 0, 0, 1, 0); tick();
    drive(1, OpAnd, 3'd1, 1, 1, 16'h8000, 0, 0, 0, 1, 0); tick();
    check("t3_and_flags", {zf, nf, cf}, 3'b010);
    drive(1, OpAdd, 3'd2, 0, 0, 16'h0000, 1, 0, 0, 1, 0); tick();
    check("t3_hold_flags", {zf, nf, cf}, 3'b010);

    // Flush while full, with a same-cycle request that must be dropped
    drive(1, OpMov, 3'd5, 1, 0, 16'h1111, 0, 0, 0, 0, 0); tick();
    drive(1, OpMov, 3'd6, 0, 0, 16'h2222, 0, 0, 0, 0, 0); tick();
    drive(1, OpAdd, 3'd7, 1, 1, 16'h0000, 1, 0, 0, 0, 1); tick();
    check("t4_flush_q", {wb_if.valid, ex_ready}, 2'b01);
    check("t4_flush_flags", {zf, nf, cf}, 3'b010);
    drive(0, OpMov, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0); tick();
    check("t4_dropped", 32'(wb_if.valid), 0);

    // Overflow detection
    drive(1, OpAdd, 3'd1, 1, 1, 16'h8000, 0, 0, 0, 1, 0); tick();
    check("t5_add_vf", 32'(vf), 32'(VfOn));
    drive(1, OpSub, 3'd1, 1, 1, 16'h7fff, 0, 1, 0, 1, 0); tick();
    check("t5_sub_vf", 32'(vf), 32'(VfOn));
    drive(1, OpXor, 3'd1, 1, 1, 16'h7fff, 0, 1, 0, 1, 0); tick();
    check("t5_xor_vf", 32'(vf), 0);

    // Asynchronous reset mid-stream
    drive(1, OpAdd, 3'd3, 1, 1, 16'h0005, 1, 0, 0, 0, 0); tick();
    drive(0, OpMov, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst", {wb_if.valid, cf, cf_to_alu, ex_ready}, 4'b0001);
    model_reset();
    @(negedge clock);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 11)], 3'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
